node_caller: RTL and testbench

NODE_CALLER -- requirements
Module: node_caller

---
 rtl/node_pkg.sv | 15 +
 rtl/node_caller_if.sv | 36 +++
 rtl/node_caller_slot.sv | 73 +++++++
 rtl/node_caller.sv | 116 +++++++++++
 tb/tb_node_caller.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/node_pkg.sv
// Shared definitions for the node start/ready handshake: caller state encoding
// and the default width/timeout used by the caller and its interface.
package node_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2
  } state_e;

  localparam int W_DEF   = 16;
  localparam int TMO_DEF = 255;
  localparam int CNT_W   = 16;

endpackage

// File: rtl/node_caller_if.sv
// Parent/child handshake bundle of the node caller; the slave modport is the
// caller itself, the master modport is the parent plus the three children.
interface node_caller_if
  import node_pkg::*;
#(
  parameter int W = W_DEF
);

  logic         ST;
  logic [2:0]   EN;
  logic         RD;
  logic         ERR;
  logic [W-1:0] OUT0;
  logic [W-1:0] OUT1;
  logic [W-1:0] OUT2;
  logic         CST0;
  logic         CST1;
  logic         CST2;
  logic         CRD0;
  logic         CRD1;
  logic         CRD2;
  logic [W-1:0] CRES0;
  logic [W-1:0] CRES1;
  logic [W-1:0] CRES2;

  modport master (
    output ST, EN, CRD0, CRD1, CRD2, CRES0, CRES1, CRES2,
    input  RD, ERR, OUT0, OUT1, OUT2, CST0, CST1, CST2
  );

  modport slave (
    input  ST, EN, CRD0, CRD1, CRD2, CRES0, CRES1, CRES2,
    output RD, ERR, OUT0, OUT1, OUT2, CST0, CST1, CST2
  );

endinterface

// File: rtl/node_caller_slot.sv
// One child channel of the node caller: start strobe, ack/done tracking and
// the result latch for that child.
module node_caller_slot
  import node_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         start_en_i,
  input  logic         en_i,
  input  logic         launch_i,
  input  logic         busy_i,
  input  logic         crd_i,
  input  logic [W-1:0] cres_i,
  output logic         cst_o,
  output logic         done_o,
  output logic [W-1:0] out_o
);

  logic         cst_q, cst_d;
  logic         ack_q, ack_d;
  logic         done_q, done_d;
  logic [W-1:0] out_q, out_d;

  // Next-state: ready must be seen low (ack) before a high ready counts as done.
  always_comb begin
    cst_d  = cst_q;
    ack_d  = ack_q;
    done_d = done_q;
    out_d  = out_q;
    if (start_i) begin
      cst_d  = start_en_i;
      ack_d  = 1'b0;
      done_d = 1'b0;
    end else if (launch_i) begin
      cst_d = 1'b0;
    end else if (busy_i && en_i && !done_q) begin
      if (!crd_i) begin
        ack_d = 1'b1;
      end else if (ack_q) begin
        done_d = 1'b1;
        out_d  = cres_i;
      end else begin
        ack_d = ack_q;
      end
    end else begin
      cst_d = cst_q;
    end
  end

  // Slot state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cst_q  <= 1'b0;
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      out_q  <= '0;
    end else begin
      cst_q  <= cst_d;
      ack_q  <= ack_d;
      done_q <= done_d;
      out_q  <= out_d;
    end
  end

  // Includes completion happening on the current edge so the caller can finish in the same cycle.
  assign done_o = !en_i || done_q || (busy_i && ack_q && crd_i);
  assign cst_o  = cst_q;
  assign out_o  = out_q;

endmodule

// File: rtl/node_caller.sv
// Initiator side of the node start/ready handshake: launches up to three
// children in parallel, collects their results and aborts on timeout.
module node_caller
  import node_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  node_caller_if.slave bus
);

  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TMO);

  state_e           state_q;
  logic             st_old_q;
  logic             arm_q;
  logic             rd_q;
  logic             err_q;
  logic [2:0]       en_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             start_s;
  logic             launch_s;
  logic             busy_s;
  logic             all_done_s;
  logic [2:0]       cst_s;
  logic [2:0]       done_s;

  // arm_q blocks a start until ST has been seen low after reset.
  assign start_s    = bus.ST & ~st_old_q & arm_q;
  assign launch_s   = (state_q == ST_LAUNCH);
  assign busy_s     = (state_q == ST_BUSY);
  assign all_done_s = &done_s;
  assign cnt_inc_s  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Call sequencing FSM with registered ready/error flags and timeout counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      st_old_q <= 1'b0;
      arm_q    <= 1'b0;
      rd_q     <= 1'b1;
      err_q    <= 1'b0;
      en_q     <= 3'b000;
      cnt_q    <= '0;
    end else begin
      st_old_q <= bus.ST;
      arm_q    <= arm_q | ~bus.ST;
      if (start_s) begin
        rd_q    <= 1'b0;
        err_q   <= 1'b0;
        en_q    <= bus.EN;
        cnt_q   <= '0;
        state_q <= ST_LAUNCH;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_IDLE;
          end
          ST_LAUNCH: begin
            if (all_done_s) begin
              rd_q    <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_BUSY;
            end
          end
          ST_BUSY: begin
            cnt_q <= cnt_inc_s;
            if (all_done_s) begin
              rd_q    <= 1'b1;
              state_q <= ST_IDLE;
            end else if (cnt_inc_s == TMO_C) begin
              err_q   <= 1'b1;
              rd_q    <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_BUSY;
            end
          end
          default: begin
            rd_q    <= 1'b1;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  node_caller_slot #(.W(W)) u_slot0 (
    .clk_i(CLK), .rst_ni(RST), .start_i(start_s), .start_en_i(bus.EN[0]),
    .en_i(en_q[0]), .launch_i(launch_s), .busy_i(busy_s), .crd_i(bus.CRD0),
    .cres_i(bus.CRES0), .cst_o(cst_s[0]), .done_o(done_s[0]), .out_o(bus.OUT0)
  );

  node_caller_slot #(.W(W)) u_slot1 (
    .clk_i(CLK), .rst_ni(RST), .start_i(start_s), .start_en_i(bus.EN[1]),
    .en_i(en_q[1]), .launch_i(launch_s), .busy_i(busy_s), .crd_i(bus.CRD1),
    .cres_i(bus.CRES1), .cst_o(cst_s[1]), .done_o(done_s[1]), .out_o(bus.OUT1)
  );

  node_caller_slot #(.W(W)) u_slot2 (
    .clk_i(CLK), .rst_ni(RST), .start_i(start_s), .start_en_i(bus.EN[2]),
    .en_i(en_q[2]), .launch_i(launch_s), .busy_i(busy_s), .crd_i(bus.CRD2),
    .cres_i(bus.CRES2), .cst_o(cst_s[2]), .done_o(done_s[2]), .out_o(bus.OUT2)
  );

  assign bus.RD   = rd_q;
  assign bus.ERR  = err_q;
  assign bus.CST0 = cst_s[0];
  assign bus.CST1 = cst_s[1];
  assign bus.CST2 = cst_s[2];

endmodule

// File: tb/tb_node_caller.sv
// Directed bench for node_caller: table of calls against behavioural child
// models, plus restart and asynchronous-reset sequences.
module tb_node_caller;

  typedef struct {
    logic [2:0]  en;
    int          l0, l1, l2;
    logic [15:0] c0, c1, c2;
    int          lat;
    logic        err;
    logic [15:0] o0, o1, o2;
  } vec_t;

  logic clk;
  logic rst_n;
  logic child_rst;
  logic [2:0] crd_m;
  int   ccnt [3];
  int   lo [3];
  int   cst_cnt [3];
  int   base [3];
  int   n_cmp;
  int   n_err;
  int   lat;
  vec_t vt [8];
  wire [2:0] cst_w;

  node_caller_if #(.W(16)) bus ();

  node_caller #(.W(16), .TMO(8)) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  assign cst_w    = {bus.CST2, bus.CST1, bus.CST0};
  assign bus.CRD0 = crd_m[0];
  assign bus.CRD1 = crd_m[1];
  assign bus.CRD2 = crd_m[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Child model: drop ready on seeing the strobe, raise it lo[i] edges later (lo=0: never).
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (child_rst) begin
        crd_m[i] <= 1'b1;
        ccnt[i]  <= 0;
      end else if (cst_w[i]) begin
        crd_m[i] <= 1'b0;
        ccnt[i]  <= lo[i];
      end else if (ccnt[i] > 1) begin
        ccnt[i] <= ccnt[i] - 1;
      end else if (ccnt[i] == 1) begin
        crd_m[i] <= 1'b1;
        ccnt[i]  <= 0;
      end
    end
  end

  // Strobe-cycle counters sampled at each rising edge.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (cst_w[i] === 1'b1) cst_cnt[i] <= cst_cnt[i] + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Counts edges after the start edge until RD is seen high (99 if it never is).
  task automatic wait_rd(output int n_edges);
    bit found;
    found   = 1'b0;
    n_edges = 99;
    for (int n = 1; n <= 20; n++) begin
      if (!found) begin
        @(posedge clk);
        #1;
        if (bus.RD === 1'b1) begin
          found   = 1'b1;
          n_edges = n;
        end
      end
    end
  endtask

  task automatic setup_children(input logic [2:0] en, input int a, input int b, input int c,
                                input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2);
    @(negedge clk);
    child_rst = 1'b1;
    bus.EN    = en;
    lo[0] = a; lo[1] = b; lo[2] = c;
    bus.CRES0 = r0; bus.CRES1 = r1; bus.CRES2 = r2;
    @(negedge clk);
    child_rst = 1'b0;
    for (int i = 0; i < 3; i++) base[i] = cst_cnt[i];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    child_rst = 1'b1;
    bus.ST = 1'b0;
    bus.EN = 3'b000;
    bus.CRES0 = 16'h0000; bus.CRES1 = 16'h0000; bus.CRES2 = 16'h0000;
    lo[0] = 0; lo[1] = 0; lo[2] = 0;

    vt[0] = '{3'b111, 2, 2, 2, 16'h0011, 16'h0022, 16'h0033, 4, 1'b0, 16'h0011, 16'h0022, 16'h0033};
    vt[1] = '{3'b101, 2, 5, 3, 16'hAA01, 16'hBB02, 16'hCC03, 5, 1'b0, 16'hAA01, 16'h0022, 16'hCC03};
    vt[2] = '{3'b111, 1, 3, 0, 16'h1111, 16'h2222, 16'h3333, 9, 1'b1, 16'h1111, 16'h2222, 16'hCC03};
    vt[3] = '{3'b000, 2, 2, 2, 16'h4444, 16'h4444, 16'h4444, 1, 1'b0, 16'h1111, 16'h2222, 16'hCC03};
    vt[4] = '{3'b010, 2, 4, 2, 16'h9999, 16'h5A5A, 16'h9999, 6, 1'b0, 16'h1111, 16'h5A5A, 16'hCC03};
    vt[5] = '{3'b011, 6, 1, 2, 16'h0606, 16'h0101, 16'h9999, 8, 1'b0, 16'h0606, 16'h0101, 16'hCC03};
    vt[6] = '{3'b100, 2, 2, 7, 16'h9999, 16'h9999, 16'h7777, 9, 1'b0, 16'h0606, 16'h0101, 16'h7777};
    vt[7] = '{3'b100, 2, 2, 8, 16'h9999, 16'h9999, 16'h8888, 9, 1'b1, 16'h0606, 16'h0101, 16'h7777};

    #1 rst_n = 1'b0;
    #1;
    chk("reset_rd", {31'd0, bus.RD}, 32'd1);
    chk("reset_err", {31'd0, bus.ERR}, 32'd0);
    chk("reset_out0", {16'd0, bus.OUT0}, 32'd0);
    chk("reset_out1", {16'd0, bus.OUT1}, 32'd0);
    chk("reset_out2", {16'd0, bus.OUT2}, 32'd0);
    chk("reset_cst", {29'd0, cst_w}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 8; v++) begin
      setup_children(vt[v].en, vt[v].l0, vt[v].l1, vt[v].l2, vt[v].c0, vt[v].c1, vt[v].c2);
      bus.ST = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rd_low", v), {31'd0, bus.RD}, 32'd0);
      wait_rd(lat);
      chk($sformatf("v%0d_latency", v), lat, vt[v].lat);
      chk($sformatf("v%0d_err", v), {31'd0, bus.ERR}, {31'd0, vt[v].err});
      chk($sformatf("v%0d_out0", v), {16'd0, bus.OUT0}, {16'd0, vt[v].o0});
      chk($sformatf("v%0d_out1", v), {16'd0, bus.OUT1}, {16'd0, vt[v].o1});
      chk($sformatf("v%0d_out2", v), {16'd0, bus.OUT2}, {16'd0, vt[v].o2});
      for (int i = 0; i < 3; i++)
        chk($sformatf("v%0d_cst%0d_pulses", v, i), cst_cnt[i] - base[i], {31'd0, vt[v].en[i]});
      @(negedge clk);
      bus.ST = 1'b0;
    end

    // Restart three BUSY cycles into a slow call; only the second call's results may land.
    setup_children(3'b111, 6, 6, 6, 16'h0A0A, 16'h0B0B, 16'h0C0C);
    bus.ST = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ST = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.ST = 1'b1;
    lo[0] = 2; lo[1] = 2; lo[2] = 2;
    bus.CRES0 = 16'h1A1A; bus.CRES1 = 16'h1B1B; bus.CRES2 = 16'h1C1C;
    @(posedge clk);
    #1;
    chk("restart_rd_low", {31'd0, bus.RD}, 32'd0);
    chk("restart_cst", {29'd0, cst_w}, 32'd7);
    wait_rd(lat);
    chk("restart_latency", lat, 4);
    chk("restart_err", {31'd0, bus.ERR}, 32'd0);
    chk("restart_out0", {16'd0, bus.OUT0}, 32'h1A1A);
    chk("restart_out1", {16'd0, bus.OUT1}, 32'h1B1B);
    chk("restart_out2", {16'd0, bus.OUT2}, 32'h1C1C);
    chk("restart_cst_pulses", cst_cnt[0] + cst_cnt[1] + cst_cnt[2] - base[0] - base[1] - base[2], 6);
    @(negedge clk);
    bus.ST = 1'b0;

    // Asynchronous reset mid-BUSY with ST held high across release.
    setup_children(3'b111, 6, 6, 6, 16'h0D0D, 16'h0E0E, 16'h0F0F);
    bus.ST = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    child_rst = 1'b1;
    #1;
    chk("areset_rd", {31'd0, bus.RD}, 32'd1);
    chk("areset_err", {31'd0, bus.ERR}, 32'd0);
    chk("areset_out0", {16'd0, bus.OUT0}, 32'd0);
    chk("areset_out1", {16'd0, bus.OUT1}, 32'd0);
    chk("areset_out2", {16'd0, bus.OUT2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) base[i] = cst_cnt[i];
    repeat (5) @(posedge clk);
    #1;
    chk("held_st_rd", {31'd0, bus.RD}, 32'd1);
    chk("held_st_no_cst", cst_cnt[0] + cst_cnt[1] + cst_cnt[2] - base[0] - base[1] - base[2], 0);
    @(negedge clk);
    bus.ST = 1'b0;
    child_rst = 1'b0;
    @(negedge clk);
    bus.ST = 1'b1;
    @(posedge clk);
    #1;
    chk("rearm_rd_low", {31'd0, bus.RD}, 32'd0);
    wait_rd(lat);
    chk("rearm_latency", lat, 8);
    chk("rearm_out2", {16'd0, bus.OUT2}, 32'h0F0F);
    @(negedge clk);
    bus.ST = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
